// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if -- bundle of every non-clock/reset signal around the multiply
// controller: EX-stage request, flush, the multiplier handshake and the
// HI/LO and GPR writeback ports.
//   slave  : the controller (mul_ctrl) side
//   master : the pipeline / multiplier side that drives requests and results
interface mul_ctrl_if;
  // requests from EX and results from the multiplier
  logic [1:0]  op_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        flush_i;
  logic [63:0] mul_result_i;
  logic        mul_ready_i;
  // controls to the multiplier, pipeline stall and writeback
  logic        signed_mul_o;
  logic [31:0] opdata1_o;
  logic [31:0] opdata2_o;
  logic        start_o;
  logic        annul_o;
  logic        stallreq_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        wreg_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o;

  modport slave (
    input  op_i, reg1_i, reg2_i, wd_i, flush_i, mul_result_i, mul_ready_i,
    output signed_mul_o, opdata1_o, opdata2_o, start_o, annul_o, stallreq_o,
           whilo_o, hi_o, lo_o, wreg_o, wd_o, wdata_o
  );

  modport master (
    output op_i, reg1_i, reg2_i, wd_i, flush_i, mul_result_i, mul_ready_i,
    input  signed_mul_o, opdata1_o, opdata2_o, start_o, annul_o, stallreq_o,
           whilo_o, hi_o, lo_o, wreg_o, wd_o, wdata_o
  );
endinterface

// File: rtl/mul_ctrl.sv
// mul_ctrl -- sequences a multi-cycle multiplier for MULT / MULTU / MUL.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset; also forces every output to 0
//   bus  : mul_ctrl_if.slave (EX request, flush, multiplier handshake,
//          HI/LO and GPR writeback)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no operation; a valid op (no flush) starts the multiplier
// WAIT  | multiplier running on latched operands; stall until ready/flush
// DRAIN | flush seen; hold annul for 2 cycles so the multiplier idles
//
// Outputs are decoded from state and live inputs in the same cycle: the
// multiplier must see start and operands in the issue cycle, and writeback
// happens in the very cycle mul_ready_i is seen.
module mul_ctrl (
  input  logic       clk,
  input  logic       rst,
  mul_ctrl_if.slave  bus
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  wd_q, wd_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        signed_mul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic        stallreq;
  logic        whilo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        wreg;
  logic [4:0]  wd;
  logic [31:0] wdata;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    wd_d       = wd_q;
    cnt_d      = cnt_q;
    signed_mul = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    start      = 1'b0;
    annul      = 1'b0;
    stallreq   = 1'b0;
    whilo      = 1'b0;
    hi         = '0;
    lo         = '0;
    wreg       = 1'b0;
    wd         = '0;
    wdata      = '0;

    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.op_i != OP_NONE && !bus.flush_i) begin
            start      = 1'b1;
            stallreq   = 1'b1;
            opdata1    = bus.reg1_i;
            opdata2    = bus.reg2_i;
            signed_mul = (bus.op_i != OP_MULTU);
            op_d       = bus.op_i;
            a_d        = bus.reg1_i;
            b_d        = bus.reg2_i;
            wd_d       = bus.wd_i;
            state_d    = S_WAIT;
          end
        end

        S_WAIT: begin
          // latched copies keep the multiplier inputs stable while the
          // pipeline keeps presenting whatever sits in EX
          opdata1    = a_q;
          opdata2    = b_q;
          signed_mul = (op_q != OP_MULTU);
          if (bus.flush_i) begin
            // flush wins over a simultaneous ready: the result is dropped
            annul   = 1'b1;
            cnt_d   = 2'd1;
            state_d = S_DRAIN;
          end else if (bus.mul_ready_i) begin
            state_d = S_IDLE;
            if (op_q == OP_MUL) begin
              wreg  = 1'b1;
              wd    = wd_q;
              wdata = bus.mul_result_i[31:0];
            end else begin
              whilo = 1'b1;
              hi    = bus.mul_result_i[63:32];
              lo    = bus.mul_result_i[31:0];
            end
          end else begin
            start    = 1'b1;
            stallreq = 1'b1;
          end
        end

        S_DRAIN: begin
          annul    = 1'b1;
          stallreq = 1'b1;
          if (cnt_q == 2'd0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.signed_mul_o = signed_mul;
  assign bus.opdata1_o    = opdata1;
  assign bus.opdata2_o    = opdata2;
  assign bus.start_o      = start;
  assign bus.annul_o      = annul;
  assign bus.stallreq_o   = stallreq;
  assign bus.whilo_o      = whilo;
  assign bus.hi_o         = hi;
  assign bus.lo_o         = lo;
  assign bus.wreg_o       = wreg;
  assign bus.wd_o         = wd;
  assign bus.wdata_o      = wdata;

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl -- directed bench for mul_ctrl. The bench plays both the
// pipeline and the multiplier: it issues ops, holds mul_ready_i low for a
// chosen latency and then presents a hand-computed product. Expected
// writebacks are queued at issue time; a negedge monitor pops and compares
// them whenever a write enable is seen.
module tb_mul_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mul_ctrl_if bus ();

  mul_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        whilo;
    logic        wreg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  wd;
    logic [31:0] wdata;
  } wb_t;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    wb_t e;
    if (!rst) begin
      if (bus.whilo_o || bus.wreg_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'({bus.whilo_o, bus.wreg_o}), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("wb_whilo", 64'(bus.whilo_o), 64'(e.whilo));
          chk("wb_wreg",  64'(bus.wreg_o),  64'(e.wreg));
          chk("wb_hi",    64'(bus.hi_o),    64'(e.hi));
          chk("wb_lo",    64'(bus.lo_o),    64'(e.lo));
          chk("wb_wd",    64'(bus.wd_o),    64'(e.wd));
          chk("wb_wdata", 64'(bus.wdata_o), 64'(e.wdata));
        end
      end else begin
        chk("nowrite_hilo_zero", {bus.hi_o, bus.lo_o}, 64'(0));
        chk("nowrite_gpr_zero",  64'({bus.wd_o, bus.wdata_o}), 64'(0));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.op_i         = 2'b00;
    bus.reg1_i       = '0;
    bus.reg2_i       = '0;
    bus.wd_i         = '0;
    bus.flush_i      = 1'b0;
    bus.mul_ready_i  = 1'b0;
    bus.mul_result_i = '0;
  endtask

  function automatic logic any_out();
    return |{bus.signed_mul_o, bus.opdata1_o, bus.opdata2_o, bus.start_o,
             bus.annul_o, bus.stallreq_o, bus.whilo_o, bus.hi_o, bus.lo_o,
             bus.wreg_o, bus.wd_o, bus.wdata_o};
  endfunction

  // lat = stalled cycles including the issue cycle; ready comes next cycle
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input int lat, input logic [63:0] prod,
                       input string tag);
    wb_t  e;
    int   stalls;
    logic sgn;
    sgn = (op != 2'b10);
    e   = '0;
    if (op == 2'b11) begin
      e.wreg  = 1'b1;
      e.wd    = wd;
      e.wdata = prod[31:0];
    end else begin
      e.whilo = 1'b1;
      e.hi    = prod[63:32];
      e.lo    = prod[31:0];
    end
    exp_q.push_back(e);
    stalls = 0;

    next_cycle();
    set_idle();
    bus.op_i   = op;
    bus.reg1_i = a;
    bus.reg2_i = b;
    bus.wd_i   = wd;
    @(negedge clk);
    if (bus.stallreq_o) stalls++;
    chk({tag, "_issue_start"},  64'(bus.start_o),      64'(1));
    chk({tag, "_issue_op1"},    64'(bus.opdata1_o),    64'(a));
    chk({tag, "_issue_op2"},    64'(bus.opdata2_o),    64'(b));
    chk({tag, "_issue_signed"}, 64'(bus.signed_mul_o), 64'(sgn));
    chk({tag, "_issue_annul"},  64'(bus.annul_o),      64'(0));

    for (int i = 1; i < lat; i++) begin
      next_cycle();
      bus.op_i   = op ^ 2'b11;
      bus.reg1_i = ~a;
      bus.reg2_i = ~b;
      bus.wd_i   = ~wd;
      @(negedge clk);
      if (bus.stallreq_o) stalls++;
      chk({tag, "_wait_start"},  64'(bus.start_o),      64'(1));
      chk({tag, "_wait_op1"},    64'(bus.opdata1_o),    64'(a));
      chk({tag, "_wait_op2"},    64'(bus.opdata2_o),    64'(b));
      chk({tag, "_wait_signed"}, 64'(bus.signed_mul_o), 64'(sgn));
    end

    next_cycle();
    bus.op_i         = op;
    bus.reg1_i       = ~a;
    bus.reg2_i       = ~b;
    bus.mul_ready_i  = 1'b1;
    bus.mul_result_i = prod;
    @(negedge clk);
    chk({tag, "_stall_cycles"},  64'(stalls),           64'(lat));
    chk({tag, "_ready_stall"},   64'(bus.stallreq_o),   64'(0));
    chk({tag, "_ready_start"},   64'(bus.start_o),      64'(0));
    chk({tag, "_ready_signed"},  64'(bus.signed_mul_o), 64'(sgn));
    chk({tag, "_ready_annul"},   64'(bus.annul_o),      64'(0));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      set_idle();
      @(negedge clk);
      chk("idle_start", 64'(bus.start_o),    64'(0));
      chk("idle_stall", 64'(bus.stallreq_o), 64'(0));
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int annuls;

    // reset, with a request present to confirm outputs stay gated
    rst = 1'b1;
    set_idle();
    bus.op_i   = 2'b01;
    bus.reg1_i = 32'h1;
    bus.reg2_i = 32'h2;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset_outputs_zero", 64'(any_out()), 64'(0));
    next_cycle();
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    chk("post_reset_idle", 64'(any_out()), 64'(0));

    // MULT -2 x 3, 35-cycle multiplier
    do_op(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0, 35, 64'hFFFF_FFFF_FFFF_FFFA, "mult_neg");
    idle_cycles(1);

    // MULTU max x max
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 4, 64'hFFFF_FFFE_0000_0001, "multu_max");
    idle_cycles(1);

    // MUL 7 x 0 into r5
    do_op(2'b11, 32'h0000_0007, 32'h0000_0000, 5'd5, 3, 64'h0, "mul_zero");
    idle_cycles(1);

    // flush alongside a request in IDLE: nothing starts
    next_cycle();
    set_idle();
    bus.op_i    = 2'b01;
    bus.reg1_i  = 32'h5;
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("idle_flush_start", 64'(bus.start_o),    64'(0));
    chk("idle_flush_stall", 64'(bus.stallreq_o), 64'(0));
    idle_cycles(1);

    // flush 10 cycles into a MULT, coinciding with a ready
    annuls = 0;
    next_cycle();
    set_idle();
    bus.op_i   = 2'b01;
    bus.reg1_i = 32'h10;
    bus.reg2_i = 32'h20;
    @(negedge clk);
    if (bus.annul_o) annuls++;
    for (int i = 1; i < 10; i++) begin
      next_cycle();
      set_idle();
      @(negedge clk);
      if (bus.annul_o) annuls++;
    end
    next_cycle();
    set_idle();
    bus.flush_i      = 1'b1;
    bus.mul_ready_i  = 1'b1;
    bus.mul_result_i = 64'h0000_0000_0000_0200;
    @(negedge clk);
    if (bus.annul_o) annuls++;
    chk("flush_start", 64'(bus.start_o),    64'(0));
    chk("flush_stall", 64'(bus.stallreq_o), 64'(0));
    next_cycle();
    set_idle();
    bus.flush_i = 1'b1;
    bus.op_i    = 2'b01;
    @(negedge clk);
    if (bus.annul_o) annuls++;
    chk("drain1_stall", 64'(bus.stallreq_o), 64'(1));
    chk("drain1_start", 64'(bus.start_o),    64'(0));
    next_cycle();
    set_idle();
    bus.op_i = 2'b01;
    @(negedge clk);
    if (bus.annul_o) annuls++;
    chk("drain2_stall", 64'(bus.stallreq_o), 64'(1));
    chk("drain2_start", 64'(bus.start_o),    64'(0));
    next_cycle();
    set_idle();
    @(negedge clk);
    if (bus.annul_o) annuls++;
    chk("after_drain_stall", 64'(bus.stallreq_o), 64'(0));
    chk("flush_annul_cycles", 64'(annuls), 64'(3));

    do_op(2'b10, 32'h2, 32'h3, 5'd0, 2, 64'h6, "multu_after_flush");
    idle_cycles(1);

    // back-to-back MULT then MUL
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5, 64'h1, "b2b_mult");
    do_op(2'b11, 32'hFFFF_FFFD, 32'h0000_0005, 5'd9, 4, 64'hFFFF_FFFF_FFFF_FFF1, "b2b_mul");
    idle_cycles(1);

    // reset pulsed mid-WAIT
    next_cycle();
    set_idle();
    bus.op_i   = 2'b01;
    bus.reg1_i = 32'h5;
    bus.reg2_i = 32'h6;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      set_idle();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midwait_rst_outputs", 64'(any_out()), 64'(0));
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_outputs", 64'(any_out()), 64'(0));
    idle_cycles(2);
    do_op(2'b01, 32'h3, 32'h4, 5'd0, 3, 64'hC, "mult_after_rst");
    idle_cycles(3);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 op_i  in  2  EX-stage op: 00 none, 01 MULT (signed, to HI/LO), 10 MULTU (unsigned, to HI/LO), 11 MUL (signed, low word to GPR).
REQ-005 reg1_i, reg2_i  in  32 each  source operands.
REQ-006 wd_i  in  5  destination GPR for MUL.
REQ-007 flush_i  in  1  pipeline flush; aborts the in-flight multiply.
REQ-008 mul_result_i  in  64  multiplier product.
REQ-009 mul_ready_i  in  1  multiplier result valid.
REQ-010 signed_mul_o  out  1  signed-multiply select to the multiplier.
REQ-011 opdata1_o, opdata2_o  out  32 each  operands to the multiplier.
REQ-012 start_o  out  1  multiplier start (1 = start/hold, 0 = stop).
REQ-013 annul_o  out  1  multiplier cancel.
REQ-014 stallreq_o  out  1  pipeline stall request.
REQ-015 whilo_o  out  1; hi_o, lo_o  out  32 each  HI/LO write enable and data.
REQ-016 wreg_o  out  1; wd_o  out  5; wdata_o  out  32  GPR write enable, address and data.

Function
REQ-017 FSM states: IDLE, WAIT, DRAIN; encoding is free.
REQ-018 IDLE with op_i!=00 and flush_i=0: start_o=1, stallreq_o=1, opdata1_o/opdata2_o driven from reg1_i/reg2_i this cycle; latch op, operands and wd_i; go WAIT.
REQ-019 signed_mul_o=1 for MULT and MUL, and 0 for MULTU; it SHALL be held constant for the whole operation.
REQ-020 IDLE with op_i=00 or flush_i=1: start_o=0, annul_o=0, stallreq_o=0, no write; stay IDLE.
REQ-021 WAIT: start_o=1, annul_o=0, operands and signed_mul_o from latched values; the live inputs are ignored.
REQ-022 WAIT with mul_ready_i=0 and flush_i=0: stallreq_o=1; stay WAIT.
REQ-023 WAIT with mul_ready_i=1 and flush_i=0: start_o=0, stallreq_o=0; go IDLE.
REQ-024 Writeback in that same cycle for MULT/MULTU: whilo_o=1, hi_o=mul_result_i[63:32], lo_o=mul_result_i[31:0].
REQ-025 Writeback in that same cycle for MUL: wreg_o=1, wd_o=latched wd, wdata_o=mul_result_i[31:0], whilo_o=0.
REQ-026 The write enables (whilo_o, wreg_o) SHALL be asserted only in the ready cycle, for exactly one cycle per operation.
REQ-027 WAIT with flush_i=1 (takes priority over mul_ready_i): start_o=0, annul_o=1, no write, stallreq_o=0; go DRAIN.
REQ-028 DRAIN lasts exactly 2 cycles (2-bit counter), with start_o=0, annul_o=1 and stallreq_o=1, so the multiplier returns to idle from any state; then go IDLE.
REQ-029 Flush during DRAIN has no additional effect.
REQ-030 The controller SHALL be latency-agnostic: it waits on mul_ready_i indefinitely, with no timeout.
REQ-031 Outside write cycles, hi_o, lo_o, wdata_o and wd_o SHALL be 0.

Reset
REQ-032 With rst=1: state IDLE, latches and counters cleared; all outputs 0.
REQ-033 Reset mid-operation in WAIT or DRAIN: discard the operation, no write; the multiplier is reset by the same rst.

Verification
REQ-034 MULT 0xFFFFFFFE x 0x00000003, issue in cycle N: stall cycles N..N+34; cycle N+35 whilo_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA; stallreq_o=0.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF: hi_o=0xFFFFFFFE, lo_o=0x00000001; wreg_o remains 0.
REQ-036 MUL wd_i=5, 7 x 0: stall 3 cycles; then wreg_o=1, wd_o=5, wdata_o=0; whilo_o=0.
REQ-037 Flush 10 cycles into a MULT: annul_o=1 for 3 cycles, no write enable ever asserted; a following MULTU 2x3 yields lo_o=6, hi_o=0.
REQ-038 Back-to-back MULT then MUL: exactly one write each, with correct data; start_o low for exactly the one ready cycle between them.
REQ-039 rst pulsed mid-WAIT: all outputs 0 the next cycle; a fresh MULT 3x4 completes with lo_o=12.
